// File: rtl/wb_buffer_if.sv
// Writeback buffer bus: ALU result push side, register-file/scoreboard retire side and forwarding lookup.
// Field widths come from REG_WID, SB_SIZE_WID and VLEN; the defaults below apply when the build does not set them.
`ifndef REG_WID
`define REG_WID 5
`endif
`ifndef SB_SIZE_WID
`define SB_SIZE_WID 3
`endif
`ifndef VLEN
`define VLEN 32
`endif

interface wb_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a head entry retires on a rising edge where out_valid and out_ready are both high.
  // The push side has no ready; the issue stage must hold off while full is high, else the push is dropped.
  logic                    in_valid;
  logic [`SB_SIZE_WID-1:0] in_pos;
  logic [`REG_WID-1:0]     in_rd;
  logic [`VLEN-1:0]        in_value;
  logic                    full;
  logic [CW-1:0]           count;
  logic                    out_valid;
  logic                    out_ready;
  logic                    rf_we;
  logic [`REG_WID-1:0]     rf_rd;
  logic [`VLEN-1:0]        rf_value;
  logic [`SB_SIZE_WID-1:0] sb_pos;
  logic                    overflow_err;
  logic [`REG_WID-1:0]     fwd_rd;
  logic                    fwd_hit;
  logic [`VLEN-1:0]        fwd_value;

  modport master (
    output in_valid, in_pos, in_rd, in_value, out_ready, fwd_rd,
    input  full, count, out_valid, rf_we, rf_rd, rf_value, sb_pos, overflow_err, fwd_hit, fwd_value
  );

  modport slave (
    input  in_valid, in_pos, in_rd, in_value, out_ready, fwd_rd,
    output full, count, out_valid, rf_we, rf_rd, rf_value, sb_pos, overflow_err, fwd_hit, fwd_value
  );
endinterface

// File: rtl/wb_buffer.sv
// Writeback buffer: circular FIFO of ALU results draining in push order to the register file and scoreboard.
// Optional macro WB_FWD_EN adds a combinational youngest-match forwarding lookup over occupied entries.
module wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("wb_buffer: DEPTH must be a power of two and at least 2");
  end

  logic [`REG_WID-1:0]     rd_mem  [DEPTH];
  logic [`VLEN-1:0]        val_mem [DEPTH];
  logic [`SB_SIZE_WID-1:0] pos_mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          ovf;

  logic is_empty;
  logic is_full;
  logic pop;
  logic push;
  logic drop;

  assign is_empty = (count == '0);
  assign is_full  = (count == CW'(DEPTH));
  assign pop      = !is_empty && bus.out_ready;
  // A pop in the same edge frees a slot, so a full buffer still accepts.
  assign push     = bus.in_valid && (!is_full || pop);
  assign drop     = bus.in_valid && is_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end

  // Storage is not reset; occupancy is tracked solely by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]  <= bus.in_rd;
      val_mem[tail] <= bus.in_value;
      pos_mem[tail] <= bus.in_pos;
    end
  end

  always_comb begin
    bus.out_valid = !is_empty;
    bus.rf_we     = 1'b0;
    bus.rf_rd     = '0;
    bus.rf_value  = '0;
    bus.sb_pos    = '0;
    if (!is_empty) begin
      bus.rf_we    = (rd_mem[head] != '0);
      bus.rf_rd    = rd_mem[head];
      bus.rf_value = val_mem[head];
      bus.sb_pos   = pos_mem[head];
    end
  end

  assign bus.full         = is_full;
  assign bus.count        = count;
  assign bus.overflow_err = ovf;

`ifdef WB_FWD_EN
  logic [AW-1:0] slot;

  // Scan oldest to youngest so the last match wins; the entry being pushed is not yet counted.
  always_comb begin
    bus.fwd_hit   = 1'b0;
    bus.fwd_value = '0;
    slot          = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + AW'(i);
      if ((CW'(i) < count) && (bus.fwd_rd != '0) && (rd_mem[slot] == bus.fwd_rd)) begin
        bus.fwd_hit   = 1'b1;
        bus.fwd_value = val_mem[slot];
      end
    end
  end
`else
  logic unused_fwd_rd;
  assign unused_fwd_rd = ^bus.fwd_rd;
  assign bus.fwd_hit   = 1'b0;
  assign bus.fwd_value = '0;
`endif
endmodule
